fb_scanout: RTL

Streaming reader for the renderer's pixel buffer. After a frame has been rendered into byte-addressed frame memory, this block walks the buffer in raster order. It fetches the three bytes of each pixel (stored B, G, R) over a fixed-latency read port, packs them into a 24-bit RGB word, and presents the pixels on a valid/ready stream with frame and line markers for the display or capture sink.

---
 rtl/fb_scanout_pkg.sv | 33 +++
 rtl/fb_scanout_fifo.sv | 77 +++++++
 rtl/fb_scanout.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_pkg.sv
// Shared rendering types for the frame-buffer scanout path: pixel and stream-flag
// structs, the FIFO word layout, byte offsets inside a pixel and the scanout FSM states.
package fb_scanout_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

  typedef struct packed {
    pix_flags_t flags;
    pixel_t     pix;
  } fifo_word_t;

  localparam logic [1:0] B_OFS = 2'd0;
  localparam logic [1:0] G_OFS = 2'd1;
  localparam logic [1:0] R_OFS = 2'd2;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/fb_scanout_fifo.sv
// fb_pixel_fifo: 2-entry pixel FIFO (24-bit RGB plus sof/eol/eof) with a registered
// head entry, so the stream data and flags come straight from flops.
module fb_pixel_fifo
  import fb_scanout_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  fifo_word_t wr_data_i,
  input  logic       rd_en_i,
  output fifo_word_t rd_data_o,
  output logic [1:0] count_o,
  output logic       full_o,
  output logic       empty_o
);

  fifo_word_t head_q, head_d;
  fifo_word_t spare_q, spare_d;
  logic [1:0] count_q, count_d;
  logic       empty_q;
  logic       pop, push;

  assign pop  = rd_en_i && (count_q != 2'd0);
  assign push = wr_en_i && ((count_q != 2'd2) || pop);

  // head always holds the oldest entry; spare only fills when head is occupied
  always_comb begin
    head_d  = head_q;
    spare_d = spare_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = wr_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = wr_data_i;
        end else if (push) begin
          spare_d = wr_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d = spare_q;
          if (push) spare_d = wr_data_i;
          else      count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      spare_q <= '0;
      count_q <= 2'd0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      spare_q <= spare_d;
      count_q <= count_d;
      empty_q <= (count_d == 2'd0);
    end
  end

  assign rd_data_o = head_q;
  assign count_o   = count_q;
  assign full_o    = (count_q == 2'd2);
  assign empty_o   = empty_q;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: raster-order frame-buffer reader producing a 24-bit RGB valid/ready stream.
// Define FB_SCANOUT_LOOP_EN for continuous scanout that repeats frames until reset.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int RES_X  = 64,
  parameter int RES_Y  = 64,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int XW = (RES_X > 1) ? $clog2(RES_X) : 1;
  localparam int YW = (RES_Y > 1) ? $clog2(RES_Y) : 1;

  state_t            state_q;
  logic              busy_q, done_q, rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        phase_q, pend_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              ret_vld_q;
  logic [1:0]        ret_phase_q;
  pix_flags_t        ret_flags_q;
  logic [7:0]        b_q, g_q;

  logic       last_x, last_y, mid_pixel, r_issue, last_issue, stop_fetch;
  logic       room, new_px, fifo_wr, hs;
  logic [2:0] occ;
  pix_flags_t cur_flags;
  fifo_word_t wr_word, rd_word;
  logic [1:0] fifo_cnt;
  logic       fifo_full, fifo_empty;

  assign last_x     = (x_q == XW'(RES_X - 1));
  assign last_y     = (y_q == YW'(RES_Y - 1));
  assign cur_flags  = '{sof: (x_q == '0) && (y_q == '0), eol: last_x, eof: last_x && last_y};
  assign mid_pixel  = rd_en_q && (phase_q != R_OFS);
  assign r_issue    = rd_en_q && (phase_q == R_OFS);
  assign last_issue = r_issue && last_x && last_y;
`ifdef FB_SCANOUT_LOOP_EN
  assign stop_fetch = 1'b0;
`else
  assign stop_fetch = last_issue;
`endif

  // pixels in flight are counted from their B read until the FIFO write
  assign occ    = {1'b0, fifo_cnt} + {1'b0, pend_q};
  assign room   = !fifo_full && (occ < 3'd2);
  assign new_px = ((state_q == ST_IDLE) && start) ||
                  ((state_q == ST_FETCH) && !mid_pixel && !stop_fetch && room);
  assign fifo_wr = ret_vld_q && (ret_phase_q == R_OFS);
  assign hs      = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      phase_q <= B_OFS;
      pend_q  <= 2'd0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      done_q  <= hs && pix_eof;
      rd_en_q <= mid_pixel || new_px;
      if (mid_pixel)   phase_q <= phase_q + 2'd1;
      else if (new_px) phase_q <= B_OFS;

      if (last_issue)   addr_q <= '0;
      else if (rd_en_q) addr_q <= addr_q + ADDR_W'(1);

      if (r_issue) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end

      case ({new_px, fifo_wr})
        2'b10:   pend_q <= pend_q + 2'd1;
        2'b01:   pend_q <= pend_q - 2'd1;
        default: pend_q <= pend_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ST_FETCH: begin
          if (stop_fetch) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs && pix_eof) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // bytes return one cycle after their read; R goes straight into the FIFO word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_vld_q   <= 1'b0;
      ret_phase_q <= B_OFS;
      ret_flags_q <= '0;
      b_q         <= '0;
      g_q         <= '0;
    end else begin
      ret_vld_q   <= rd_en_q;
      ret_phase_q <= phase_q;
      if (r_issue) ret_flags_q <= cur_flags;
      if (ret_vld_q && (ret_phase_q == B_OFS)) b_q <= mem_rdata;
      if (ret_vld_q && (ret_phase_q == G_OFS)) g_q <= mem_rdata;
    end
  end

  assign wr_word = '{flags: ret_flags_q, pix: '{r: mem_rdata, g: g_q, b: b_q}};

  fb_pixel_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_word),
    .rd_en_i   (pix_ready),
    .rd_data_o (rd_word),
    .count_o   (fifo_cnt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign pix_valid = !fifo_empty;
  assign pix_data  = rd_word.pix;
  assign pix_sof   = rd_word.flags.sof;
  assign pix_eol   = rd_word.flags.eol;
  assign pix_eof   = rd_word.flags.eof;

endmodule
